// File: rtl/seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seq_scan_ctrl
//
// Serialises a latched word MSB first and runs a PAT_W-bit pattern matcher on
// the resulting bit stream. The matcher is a Moore detector: a match found on a
// bit is reported on y during the following cycle. Matches are counted with a
// saturating counter. In overlapping mode the bits of a match may be reused
// for later matches; in non-overlapping mode the valid-bit count restarts after
// every match.
//
// Ports
//   clk       in   1       clock, all state updates on the rising edge
//   reset     in   1       synchronous active-high reset
//   start     in   1       scan request, honoured only in IDLE
//   word_in   in   WORD_W  word to scan, sampled with an accepted start
//   pattern   in   PAT_W   target pattern, sampled with an accepted start
//   overlap   in   1       1 = overlapping matches, sampled with accepted start
//   din       out  1       serial bit currently presented to the matcher
//   y         out  1       registered match flag
//   busy      out  1       high while shifting
//   done      out  1       one-cycle end-of-scan pulse
//   match_cnt out  CNT_W   matches found in the current or last scan
// -----------------------------------------------------------------------------
module seq_scan_ctrl #(
   parameter int WORD_W = 8,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] word_in,
   input  logic [PAT_W-1:0]  pattern,
   input  logic              overlap,
   output logic              din,
   output logic              y,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  match_cnt
);

   localparam int IDX_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam int VLD_W = $clog2(PAT_W + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  word_q,  word_d;
   logic [PAT_W-1:0]   pat_q,   pat_d;
   logic               ovl_q,   ovl_d;
   // Only the PAT_W-1 older bits are stored; the incoming bit completes the
   // PAT_W-bit window, so the oldest bit would never be looked at again.
   logic [PAT_W-2:0]   hist_q,  hist_d;
   logic [VLD_W-1:0]   vld_q,   vld_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               din_q,   din_d;
   logic               y_q,     y_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;

   logic [PAT_W-1:0]   window_s;
   logic [VLD_W-1:0]   vld_inc_s;
   logic               match_s;

   // Matcher datapath: current PAT_W-bit window and match qualification.
   always_comb begin
      window_s  = {hist_q, word_q[WORD_W-1]};
      // Valid-bit count saturates at PAT_W; beyond that it carries no news.
      if (vld_q == VLD_W'(PAT_W)) begin
         vld_inc_s = vld_q;
      end else begin
         vld_inc_s = vld_q + VLD_W'(1);
      end
      match_s = (state_q == S_SHIFT) &&
                (window_s == pat_q) &&
                (vld_inc_s == VLD_W'(PAT_W));
   end

   // Next-state and registered-output logic for the scan FSM.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      pat_d   = pat_q;
      ovl_d   = ovl_q;
      hist_d  = hist_q;
      vld_d   = vld_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      din_d   = 1'b0;
      y_d     = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               word_d  = word_in;
               pat_d   = pattern;
               ovl_d   = overlap;
               hist_d  = {(PAT_W-1){1'b0}};
               vld_d   = {VLD_W{1'b0}};
               idx_d   = {IDX_W{1'b0}};
               cnt_d   = {CNT_W{1'b0}};
               din_d   = word_in[WORD_W-1];
               busy_d  = 1'b1;
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_SHIFT: begin
            word_d = word_q << 1;
            hist_d = window_s[PAT_W-2:0];
            if (match_s) begin
               y_d = 1'b1;
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = cnt_q;
               end
               // Non-overlapping: bits of this match may not seed the next one.
               if (ovl_q) begin
                  vld_d = vld_inc_s;
               end else begin
                  vld_d = {VLD_W{1'b0}};
               end
            end else begin
               vld_d = vld_inc_s;
            end

            if (idx_q == IDX_W'(WORD_W - 1)) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               din_d   = word_q[WORD_W-2];
               busy_d  = 1'b1;
               state_d = S_SHIFT;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         word_q  <= {WORD_W{1'b0}};
         pat_q   <= {PAT_W{1'b0}};
         ovl_q   <= 1'b0;
         hist_q  <= {(PAT_W-1){1'b0}};
         vld_q   <= {VLD_W{1'b0}};
         idx_q   <= {IDX_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         din_q   <= 1'b0;
         y_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         pat_q   <= pat_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         vld_q   <= vld_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign din       = din_q;
   assign y         = y_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign match_cnt = cnt_q;

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8: bits per scanned word, MSB first.
REQ-002 SHALL have parameter PAT_W, default 4: pattern length in bits, 2 <= PAT_W <= WORD_W.
REQ-003 SHALL have parameter CNT_W, default 4: match counter width, 2**CNT_W-1 >= WORD_W.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port start  input  1: request a scan; honoured only in IDLE.
REQ-007 SHALL have port word_in  input  WORD_W: word to scan, sampled with accepted start.
REQ-008 SHALL have port pattern  input  PAT_W: target pattern, sampled with accepted start.
REQ-009 SHALL have port overlap  input  1: 1 = overlapping matches, 0 = history clears after each match; sampled with accepted start.
REQ-010 SHALL have port din  output  1: serial bit currently presented to the matcher.
REQ-011 SHALL have port y  output  1: registered (Moore) match flag.
REQ-012 SHALL have port busy  output  1: high while shifting.
REQ-013 SHALL have port done  output  1: one-cycle end-of-scan pulse.
REQ-014 SHALL have port match_cnt  output  CNT_W: matches found in the current or last scan.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 IDLE: on start=1, SHALL latch word_in, pattern and overlap, clear history, valid-bit count and match_cnt, and enter SHIFT next cycle.
REQ-017 SHIFT: cycle k (k=0..WORD_W-1 after entry) SHALL drive din = latched word bit WORD_W-1-k and shift it into a PAT_W-bit history register at the clock edge.
REQ-018 SHALL detect a match when history including the new bit equals the pattern and at least PAT_W valid bits have accumulated since scan start or the last clear.
REQ-019 On a match, SHALL set y=1 for exactly the next cycle and increment match_cnt, saturating at all-ones.
REQ-020 On a match with overlap=0, SHALL reset the valid-bit count to 0, so the new bit is not reused.
REQ-021 After bit k=WORD_W-1, SHALL enter DONE; DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-022 Latency: start accepted in cycle 0, SHIFT occupies cycles 1..WORD_W, DONE occurs in cycle WORD_W+1; a match on the last bit SHALL show y=1 in the DONE cycle.
REQ-023 match_cnt SHALL be final when done=1 and SHALL hold until the next accepted start.
REQ-024 busy SHALL be 1 exactly in SHIFT; start in SHIFT or DONE SHALL be ignored, with no queueing.
REQ-025 din SHALL be 0 outside SHIFT; y SHALL be 0 except in the cycle after a match.
REQ-026 Input changes on word_in, pattern or overlap after acceptance SHALL NOT affect the scan in progress.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE and set din, y, busy, done, match_cnt, history and valid-bit count to 0, overriding start in the same cycle.
REQ-028 reset asserted in SHIFT or DONE SHALL abort the scan with no done pulse; the first start after reset is released SHALL behave as a fresh scan.

Verification
REQ-029 word_in=8'hAA, pattern=4'hA, overlap=1 -> din stream 1,0,1,0,1,0,1,0 in cycles 1..8; y high in cycles 5, 7, 9; done in cycle 9; match_cnt=3.
REQ-030 Same stimulus with overlap=0 -> y high in cycles 5, 9; match_cnt=2.
REQ-031 word_in=8'h00, pattern=4'h0 -> overlap=1 gives match_cnt=5; overlap=0 gives match_cnt=2.
REQ-032 start pulsed in cycles 3 and 9 of a scan -> both ignored; busy and done timing unchanged; the next scan begins only after a start seen in IDLE.
REQ-033 reset asserted in cycle 4 of a scan -> next cycle all outputs 0, no done pulse; a new start then yields the correct count.
REQ-034 word_in=8'hF0, pattern=4'h5, overlap=1 -> y never asserted; done in cycle 9; match_cnt=0.
